// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM state, funct3 size
// codes, per-size byte-enable masks and the size-to-byte-count helper.
package lsu_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } lsu_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [7:0] BE_B = 8'h01;
  localparam logic [7:0] BE_H = 8'h03;
  localparam logic [7:0] BE_W = 8'h0F;
  localparam logic [7:0] BE_D = 8'hFF;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] be_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return BE_B;
      SZ_H:    return BE_H;
      SZ_W:    return BE_W;
      default: return BE_D;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request / data-memory bundle of the load/store unit. The slave modport
// is the LSU side; the master modport is the core plus data memory side.
interface load_store_unit_if #(
  parameter int XLEN           = 64,
  parameter int MEM_DEPTH_LOG2 = 5
);
  import lsu_pkg::*;

  // A request transfers on a clk edge where req_valid && req_ready; ready
  // drops only for the cycle carrying the second half of a split access.
  logic                      req_valid;
  logic                      req_ready;
  logic                      mem_read;
  logic                      mem_write;
  logic [2:0]                funct3;
  logic [XLEN-1:0]           addr;
  logic [XLEN-1:0]           wdata;
  logic [MEM_DEPTH_LOG2-1:0] dmem_idx;
  logic                      dmem_we;
  logic                      dmem_re;
  logic [7:0]                dmem_be;
  logic [63:0]               dmem_wdata;
  logic [63:0]               dmem_rdata;
  logic                      resp_valid;
  logic [XLEN-1:0]           load_data;
  logic                      misalign_err;
  lsu_state_t                state_dbg;

  modport slave (
    input  req_valid, mem_read, mem_write, funct3, addr, wdata, dmem_rdata,
    output req_ready, dmem_idx, dmem_we, dmem_re, dmem_be, dmem_wdata,
           resp_valid, load_data, misalign_err, state_dbg
  );

  modport master (
    output req_valid, mem_read, mem_write, funct3, addr, wdata, dmem_rdata,
    input  req_ready, dmem_idx, dmem_we, dmem_re, dmem_be, dmem_wdata,
           resp_valid, load_data, misalign_err, state_dbg
  );

endinterface

// File: rtl/load_store_unit_extend.sv
// Combinational load-result extension: sign- or zero-extends the low
// 1/2/4/8 bytes of the assembled load bytes to XLEN.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [63:0]     raw_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_B:    data_o = {{(XLEN-8){raw_i[7] & ~unsigned_i}}, raw_i[7:0]};
      SZ_H:    data_o = {{(XLEN-16){raw_i[15] & ~unsigned_i}}, raw_i[15:0]};
      SZ_W:    data_o = {{(XLEN-32){raw_i[31] & ~unsigned_i}}, raw_i[31:0]};
      default: data_o = XLEN'(raw_i);
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit for the 64-bit doubleword data memory; splits 8-byte-boundary
// crossings into two cycles, or traps them when built with LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int MEM_DEPTH_LOG2 = 5
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  lsu_state_t                state_q, state_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]           load_data_q, load_data_d;
  logic [MEM_DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [2:0]                lane_q, lane_d;
  logic [1:0]                sz_q, sz_d;
  logic                      uns_q, uns_d;
  logic                      is_load_q, is_load_d;
  logic [7:0]                be1_q, be1_d;
  logic [63:0]               wd1_q, wd1_d;
  logic [63:0]               part0_q, part0_d;

  logic [2:0]                req_lane;
  logic [1:0]                req_sz;
  logic                      req_uns, req_load, req_access, req_cross;
  logic [MEM_DEPTH_LOG2-1:0] req_idx;
  logic [4:0]                end_lane;
  logic [15:0]               be16;
  logic [127:0]              wd128;
  logic [63:0]               rd_shift, split_rd, ext_raw;
  logic [1:0]                ext_sz;
  logic                      ext_uns;
  logic [XLEN-1:0]           ext_result;

  logic                      req_ready_c, we_c, re_c;
  logic [MEM_DEPTH_LOG2-1:0] idx_c;
  logic [7:0]                be_c;
  logic [63:0]               wdata_c;

  logic                      unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[XLEN-1:3+MEM_DEPTH_LOG2];

  assign req_lane   = bus.addr[2:0];
  assign req_sz     = bus.funct3[1:0];
  assign req_uns    = bus.funct3[2];
  assign req_idx    = bus.addr[3 +: MEM_DEPTH_LOG2];
  assign req_load   = bus.mem_read & ~bus.mem_write;
  assign req_access = bus.mem_write ? ~bus.funct3[2] : (req_load && bus.funct3 != 3'b111);
  assign end_lane   = {2'b00, req_lane} + {1'b0, size_bytes(req_sz)};
  assign req_cross  = end_lane > 5'd8;

  // Upper halves of the 16-byte views are exactly the part-1 lanes/data.
  assign be16     = {8'h00, be_mask(req_sz)} << req_lane;
  assign wd128    = {64'h0, bus.wdata[63:0]} << {req_lane, 3'b000};
  assign rd_shift = bus.dmem_rdata >> {req_lane, 3'b000};
  assign split_rd = part0_q | (bus.dmem_rdata << {4'd8 - {1'b0, lane_q}, 3'b000});

  assign ext_raw = (state_q == SPLIT) ? split_rd : rd_shift;
  assign ext_sz  = (state_q == SPLIT) ? sz_q : req_sz;
  assign ext_uns = (state_q == SPLIT) ? uns_q : req_uns;

  lsu_extend #(.XLEN(XLEN)) u_extend (
    .raw_i      (ext_raw),
    .size_i     (ext_sz),
    .unsigned_i (ext_uns),
    .data_o     (ext_result)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`endif

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    load_data_d  = load_data_q;
    idx_d        = idx_q;
    lane_d       = lane_q;
    sz_d         = sz_q;
    uns_d        = uns_q;
    is_load_d    = is_load_q;
    be1_d        = be1_q;
    wd1_d        = wd1_q;
    part0_d      = part0_q;
    req_ready_c  = 1'b0;
    idx_c        = '0;
    be_c         = 8'h00;
    we_c         = 1'b0;
    re_c         = 1'b0;
    wdata_c      = 64'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          resp_valid_d = 1'b1;
          if (req_access) begin
            idx_d     = req_idx;
            lane_d    = req_lane;
            sz_d      = req_sz;
            uns_d     = req_uns;
            is_load_d = req_load;
            be1_d     = be16[15:8];
            wd1_d     = wd128[127:64];
            part0_d   = rd_shift;
            if (req_cross) begin
`ifdef LSU_MISALIGN_TRAP_EN
              misalign_d = 1'b1;
`else
              idx_c        = req_idx;
              be_c         = be16[7:0];
              we_c         = ~req_load;
              re_c         = req_load;
              wdata_c      = wd128[63:0];
              resp_valid_d = 1'b0;
              state_d      = SPLIT;
`endif
            end else begin
              idx_c   = req_idx;
              be_c    = be16[7:0];
              we_c    = ~req_load;
              re_c    = req_load;
              wdata_c = wd128[63:0];
              if (req_load) load_data_d = ext_result;
            end
          end else if (req_load && bus.funct3 == 3'b111) begin
            load_data_d = '0;
          end
        end
      end
      SPLIT: begin
        idx_c        = idx_q + 1'b1;
        be_c         = be1_q;
        we_c         = ~is_load_q;
        re_c         = is_load_q;
        wdata_c      = wd1_q;
        resp_valid_d = 1'b1;
        if (is_load_q) load_data_d = ext_result;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      load_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      load_data_q  <= load_data_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
  assign bus.misalign_err = misalign_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    idx_q     <= idx_d;
    lane_q    <= lane_d;
    sz_q      <= sz_d;
    uns_q     <= uns_d;
    is_load_q <= is_load_d;
    be1_q     <= be1_d;
    wd1_q     <= wd1_d;
    part0_q   <= part0_d;
  end

  // Reset suppresses strobes so an interrupted split never issues part 1.
  assign bus.req_ready  = req_ready_c;
  assign bus.dmem_idx   = reset ? '0 : idx_c;
  assign bus.dmem_be    = reset ? 8'h00 : be_c;
  assign bus.dmem_we    = we_c & ~reset;
  assign bus.dmem_re    = re_c & ~reset;
  assign bus.dmem_wdata = reset ? 64'h0 : wdata_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.load_data  = load_data_q;
  assign bus.state_dbg  = state_q;

endmodule
